// File: rtl/dat_mem_dma.sv
// dat_mem_dma -- block copy / block fill engine for an 8-bit x 256-word data memory.
//
// The engine drives the initiator side of a memory port that has
// combinational reads and clocked writes.
//   Copy: alternates READ (fetch src word into the buffer) and WRITE (store
//         the buffer at dst).
//   Fill: stays in WRITE and stores the latched fill value at consecutive
//         dst addresses.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle request, sampled only while idle
//   mode        0 = copy (src -> dst), 1 = fill (fill_val -> dst)
//   src_addr    copy source base address
//   dst_addr    destination base address
//   len         word count (0 = no transfer)
//   fill_val    fill pattern
//   mem_rd_data memory read data (combinational from mem_addr)
//   mem_addr    memory address
//   mem_wr_data memory write data (0 whenever mem_wr_en is low)
//   mem_rd_en   memory read enable
//   mem_wr_en   memory write enable
//   busy        high while reading or writing
//   done        one-cycle completion pulse
//   checksum    sum modulo 2^DW of every word written by the last operation
//               (present only when DMA_CHECKSUM_EN is defined)
//
// All outputs are decoded from registered state only. An asynchronous reset
// therefore drops every output, mem_wr_en included, without waiting for a
// clock edge.
module dat_mem_dma #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill_val,
  input  logic [DW-1:0] mem_rd_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic          busy,
  output logic          done
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q,   state_d;
  logic [AW-1:0] src_ptr_q, src_ptr_d;
  logic [AW-1:0] dst_ptr_q, dst_ptr_d;
  logic [AW-1:0] count_q,   count_d;
  logic [DW-1:0] buf_q,     buf_d;
  logic [DW-1:0] fill_q,    fill_d;
  logic          mode_q,    mode_d;
  logic [DW-1:0] wr_word;

  // Word stored in a WRITE cycle: the fetched word when copying, the pattern when filling.
  assign wr_word = mode_q ? fill_q : buf_q;

  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    count_d   = count_q;
    buf_d     = buf_q;
    fill_d    = fill_q;
    mode_d    = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_ptr_d = src_addr;
          dst_ptr_d = dst_addr;
          count_d   = len;
          fill_d    = fill_val;
          mode_d    = mode;
          if (len == '0)  state_d = S_DONE;
          else if (!mode) state_d = S_READ;
          else            state_d = S_WRITE;
        end
      end
      S_READ: begin
        buf_d   = mem_rd_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Both pointers wrap naturally at 2^AW.
        src_ptr_d = src_ptr_q + AW'(1);
        dst_ptr_d = dst_ptr_q + AW'(1);
        count_d   = count_q - AW'(1);
        if (count_q == AW'(1)) state_d = S_DONE;
        else if (mode_q)       state_d = S_WRITE;
        else                   state_d = S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      count_q   <= '0;
      buf_q     <= '0;
      fill_q    <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      count_q   <= count_d;
      buf_q     <= buf_d;
      fill_q    <= fill_d;
      mode_q    <= mode_d;
    end
  end

  // Moore output decode.
  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_READ: begin
        mem_addr  = src_ptr_q;
        mem_rd_en = 1'b1;
        busy      = 1'b1;
      end
      S_WRITE: begin
        mem_addr    = dst_ptr_q;
        mem_wr_data = wr_word;
        mem_wr_en   = 1'b1;
        busy        = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef DMA_CHECKSUM_EN
  logic [DW-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == S_IDLE && start) checksum_d = '0;
    else if (state_q == S_WRITE)    checksum_d = checksum_q + wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_dat_mem_dma.sv
module tb_dat_mem_dma;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] src_addr, dst_addr, len, fill_val;
  logic [7:0] mem_rd_data, mem_addr, mem_wr_data;
  logic       mem_rd_en, mem_wr_en, busy, done;
`ifdef DMA_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_q [$];   // {addr, data} of each expected write, in order

  always #5 clk = ~clk;

  dat_mem_dma dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
    .mem_rd_data(mem_rd_data), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .busy(busy), .done(done)
`ifdef DMA_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // Data memory: combinational read, clocked write.
  assign mem_rd_data = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("rd_wr_excl", {31'd0, mem_rd_en & mem_wr_en}, 32'd0);
      if (mem_wr_en) begin
        if (exp_q.size() == 0) chk("unexpected_wr", {24'd0, mem_addr}, 32'hFFFF);
        else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
          chk("wr_data", {24'd0, mem_wr_data}, {24'd0, e[7:0]});
          $display("write addr=0x%02h data=0x%02h", mem_addr, mem_wr_data);
        end
      end else begin
        chk("wr_data_idle", {24'd0, mem_wr_data}, 32'd0);
      end
    end
  end

  task automatic mem_image(input string tag);
    int diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk(tag, diffs, 0);
  endtask

  task automatic scramble_inputs();
    mode = 1'($urandom); src_addr = 8'($urandom); dst_addr = 8'($urandom);
    len = 8'($urandom); fill_val = 8'($urandom);
  endtask

  // Runs one operation starting at a negedge; inj > 0 raises a stray start
  // (dst 0x40) during that cycle, which must be ignored.
  task automatic run_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] n, input logic [7:0] f, input int inj);
    int lat;
    logic [7:0] sum, w, a;
    lat = (n == 0) ? 1 : (m ? int'(n) + 1 : 2 * int'(n) + 1);
    sum = 8'd0;
    for (int i = 0; i < int'(n); i++) begin
      a = s + 8'(i);
      w = m ? f : ref_mem[a];
      a = d + 8'(i);
      ref_mem[a] = w;
      exp_q.push_back({a, w});
      sum = sum + w;
    end
    mode = m; src_addr = s; dst_addr = d; len = n; fill_val = f; start = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("busy", {31'd0, busy}, {31'd0, c < lat});
      chk("done", {31'd0, done}, {31'd0, c == lat});
      chk("rd_en", {31'd0, mem_rd_en}, {31'd0, !m && c < lat && (c % 2 == 1)});
      chk("wr_en", {31'd0, mem_wr_en}, {31'd0, c < lat && (m || c % 2 == 0)});
`ifdef DMA_CHECKSUM_EN
      if (c == lat) chk("checksum", {24'd0, checksum}, {24'd0, sum});
`endif
      scramble_inputs();
      start = (c == inj);
      if (c == inj) begin dst_addr = 8'h40; len = 8'd3; end
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
`ifdef DMA_CHECKSUM_EN
    chk("checksum_held", {24'd0, checksum}, {24'd0, sum});
`endif
    chk("sb_empty", exp_q.size(), 0);
    mem_image("mem_image");
    $display("op mode=%0d src=0x%02h dst=0x%02h len=%0d fill=0x%02h lat=%0d", m, s, d, n, f, lat);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom); ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[8'h10 + i] = 8'(8'h11 * (i + 1)); ref_mem[8'h10 + i] = mem[8'h10 + i];
    end
    start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0; len = '0; fill_val = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_addr", {24'd0, mem_addr}, 32'd0);
`ifdef DMA_CHECKSUM_EN
    chk("rst_checksum", {24'd0, checksum}, 32'd0);
`endif
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    run_op(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 0);     // copy 11,22,33,44
    run_op(1'b1, 8'h00, 8'hFE, 8'd3, 8'hA5, 0);     // fill across the wrap
    run_op(1'b0, 8'h10, 8'h60, 8'd0, 8'h00, 0);     // zero length, copy
    run_op(1'b1, 8'h10, 8'h60, 8'd0, 8'h77, 1);     // zero length, fill, start in DONE
    run_op(1'b0, 8'h30, 8'h90, 8'd5, 8'h00, 3);     // stray start mid-copy
    run_op(1'b1, 8'h00, 8'hC0, 8'd4, 8'h80, 0);     // fill 0x80 x4, sum wraps to 0
    run_op(1'b0, 8'h10, 8'hD0, 8'd4, 8'h00, 0);     // copy again, sum 0xAA
    run_op(1'b0, 8'hF0, 8'hF3, 8'd20, 8'h00, 0);    // overlapping copy with wrap
    for (int k = 0; k < 4; k++)
      run_op(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 12)),
             8'($urandom), int'($urandom_range(0, 6)));

    // Reset during the third WRITE of an 8-word copy.
    mon_en = 1'b0;
    mode = 1'b0; src_addr = 8'h20; dst_addr = 8'hA0; len = 8'd8; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_wr_en", {31'd0, mem_wr_en}, 32'd1);
    chk("pre_rst_addr", {24'd0, mem_addr}, 32'hA2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("arst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("arst_wr_data", {24'd0, mem_wr_data}, 32'd0);
    chk("arst_addr", {24'd0, mem_addr}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    ref_mem[8'hA0] = ref_mem[8'h20];
    ref_mem[8'hA1] = ref_mem[8'h21];
    @(negedge clk);
    @(negedge clk);
    mem_image("rst_mem_image");
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    run_op(1'b0, 8'h20, 8'hA0, 8'd8, 8'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dat_mem_dma.md
Name: dat_mem_dma

Overview:
- Initiator-side engine that drives the 8-bit x 256-word data memory's read/write port to perform block copy and block fill operations without CPU involvement.
- Sits between the controller/top level and the data memory.
- The memory presents combinational reads and clocked writes; this block generates the address, write data, read enable and write enable sequences for that memory.
- Reports busy/done status back to the controller.

Parameters:
AW, 8, address width; the address space is 2^AW words and pointers wrap modulo 2^AW.
DW, 8, data width of a memory word.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- mode  input  1  0 = copy (src->dst), 1 = fill (fill_val->dst).
- src_addr  input  AW  copy source base; ignored in fill mode.
- dst_addr  input  AW  destination base.
- len  input  AW  word count; 0 means no transfer.
- fill_val  input  DW  fill pattern.
- mem_rd_data  input  DW  memory read data (combinational from mem_addr).
- mem_addr  output  AW  memory address.
- mem_wr_data  output  DW  memory write data.
- mem_rd_en  output  1  memory read enable.
- mem_wr_en  output  1  memory write enable.
- busy  output  1  high in READ and WRITE states.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0.
  - Internal pointers, count and data buffer cleared.
  - Reset asserted mid-transfer aborts the operation immediately; mem_wr_en falls without waiting for clk, and no further writes occur.
- Outputs are Moore-style, decoded from registered state, pointers and buffer only. No combinational path from any input to any output.
- States: IDLE, READ, WRITE, DONE.
- IDLE, start=1 at a posedge:
  - Latch src_addr, dst_addr, len, fill_val and mode.
  - If len=0: go to DONE.
  - Else if mode=0: go to READ.
  - Else: go to WRITE.
- IDLE, start=0: stay in IDLE. mem_* outputs are all 0.
- READ (copy only):
  - mem_addr=src_ptr, mem_rd_en=1, mem_wr_en=0.
  - At the posedge: buffer <= mem_rd_data; go to WRITE.
- WRITE:
  - mem_addr=dst_ptr, mem_wr_en=1, mem_rd_en=0.
  - mem_wr_data = buffer (copy) or latched fill_val (fill).
  - At the posedge: src_ptr++ and dst_ptr++, both modulo 2^AW; count--.
  - If count reaches 0: go to DONE.
  - Else: go to READ (copy) or stay in WRITE (fill).
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
- Latency from the start edge to the done pulse:
  - copy: 2*len cycles + 1;
  - fill: len cycles + 1;
  - len=0: 1 cycle.
- start while not in IDLE (including DONE) is ignored. It is not queued.
- Input operands may change freely after the start edge; only latched copies are used.
- Address wrap: 0xFF+1 = 0x00 for both pointers.
- Overlapping copy regions proceed in ascending address order with no hazard protection.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- mem_wr_data = 0 whenever mem_wr_en = 0.

Optional Feature:
- Macro: DMA_CHECKSUM_EN.
- When defined:
  - Adds output checksum [DW-1:0].
  - checksum is cleared to 0 on an accepted start.
  - In every WRITE cycle, checksum <= checksum + written word, modulo 2^DW.
  - The value holds from DONE until the next accepted start.
  - checksum resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Copy: preload mem[0x10..0x13]=11,22,33,44; start mode=0, src=0x10, dst=0x80, len=4.
  - Expect 8 busy cycles with alternating rd_en/wr_en.
  - Expect a done pulse on cycle 9 after start.
  - Expect mem[0x80..0x83]=11,22,33,44 and source unchanged.
- Fill with wrap: mode=1, dst=0xFE, len=3, fill_val=0xA5.
  - Expect writes to 0xFE, 0xFF, 0x00 on consecutive cycles.
  - Expect done on cycle 4 and mem[0x01] untouched.
- Zero length: len=0 in either mode.
  - Expect no rd_en/wr_en ever, and done exactly 1 cycle after start.
- Start while busy: a second start with dst=0x40 issued mid-copy.
  - Expect it ignored: no writes to 0x40 and a single done pulse.
- Reset mid-copy: assert rst_n=0 between clock edges during a WRITE of a len=8 copy.
  - Expect mem_wr_en to drop immediately and all outputs 0.
  - Expect only the words committed before reset to have been copied.
  - Expect the engine in IDLE and accepting a new start after release.
- DMA_CHECKSUM_EN: fill len=4 with 0x80.
  - Expect checksum=0x00 (wrap).
  - Then copy 11,22,33,44 → expect checksum=0xAA, held after done.
